// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_conditioner_pkg
//
// Shared constants for the board input conditioner: clock rate, debounce and
// auto-repeat timing defaults, default pin polarity mask and channel indices.
//
// Optional feature macro: INPUT_CONDITIONER_REPEAT_EN (auto-repeat on press).
// The repeat timing defaults below are harmless when the macro is undefined.
// -----------------------------------------------------------------------------
package input_conditioner_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 20;

    // Number of cycles a changed input must stay stable before it is accepted.
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // Auto-repeat timing: 500 ms to the first repeat, then every 200 ms.
    localparam int REPEAT_DELAY_DEFAULT  = 25_000_000;
    localparam int REPEAT_PERIOD_DEFAULT = 10_000_000;

    localparam int N_IN_DEFAULT = 5;

    // Keys are wired active-low, the enter switch is active-high.
    localparam logic [N_IN_DEFAULT-1:0] ACTIVE_LOW_MASK_DEFAULT = 5'b01111;

    // Channel positions within raw_in / level / press / release_pulse.
    typedef enum logic [2:0] {
        CH_KEY0  = 3'd0,
        CH_KEY1  = 3'd1,
        CH_KEY2  = 3'd2,
        CH_KEY3  = 3'd3,
        CH_ENTER = 3'd4
    } channel_e;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//
// One input bit: polarity normalisation, 2-flop synchronizer, counter-based
// debouncer and registered edge detector, plus optional auto-repeat.
//
// Optional feature macro: INPUT_CONDITIONER_REPEAT_EN. When defined, a hold
// counter re-fires press after REPEAT_DELAY cycles of continuous assertion and
// then every REPEAT_PERIOD cycles until the input is released.
//
// Ports:
//   clock_50      in   system clock
//   reset         in   synchronous, active-high reset
//   raw           in   asynchronous pin level
//   level         out  debounced state, 1 = asserted
//   press         out  one-cycle pulse on accepted 0->1 (and repeats)
//   release_pulse out  one-cycle pulse on accepted 1->0
//                      (named this way because `release` is a reserved word)
// -----------------------------------------------------------------------------
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic clock_50,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("debounce_channel: illegal timing parameter");
    end

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          accept;

    // The synchronized input has differed from level for the full window.
    assign accept = (s2 != level) && (cnt == CNT_LAST);

`ifdef INPUT_CONDITIONER_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

    logic [HW-1:0] hold;
    logic          repeating;
    logic [HW-1:0] hold_last;

    // First repeat waits the long delay, later ones the shorter period.
    assign hold_last = repeating ? PERIOD_LAST : DELAY_LAST;
`endif

    // Synchronizer, debounce counter and edge pulses. Normalising polarity
    // ahead of s1 makes every register reset to the inactive state, so
    // reset itself never looks like an actuation.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            s1            <= raw ^ ACTIVE_LOW;
            s2            <= s1;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt           <= '0;
                level         <= s2;
                press         <= s2;
                release_pulse <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
`ifdef INPUT_CONDITIONER_REPEAT_EN
            // A repeat landing on the release cycle is dropped so press and
            // release are never high together.
            if (!level) begin
                hold      <= '0;
                repeating <= 1'b0;
            end else if (hold == hold_last) begin
                hold      <= '0;
                repeating <= 1'b1;
                if (!accept) begin
                    press <= 1'b1;
                end
            end else begin
                hold <= hold + 1'b1;
            end
`endif
        end
`ifdef INPUT_CONDITIONER_REPEAT_EN
        if (reset) begin
            hold      <= '0;
            repeating <= 1'b0;
        end
`endif
    end

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Cleans up the raw board inputs (key[3:0] active-low, sw[0] enter
// active-high) for the game controller: one independent debounce_channel per
// input, producing a normalised level and one-cycle press/release pulses.
//
// Optional feature macro: INPUT_CONDITIONER_REPEAT_EN (auto-repeat press
// while an input is held).
//
// Ports:
//   clock_50      in   [1]     50 MHz system clock
//   reset         in   [1]     synchronous, active-high reset
//   raw_in        in   [N_IN]  asynchronous pin levels
//   level         out  [N_IN]  debounced state, 1 = asserted
//   press         out  [N_IN]  one-cycle pulse on accepted press (and repeats)
//   release_pulse out  [N_IN]  one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int              N_IN            = N_IN_DEFAULT,
    parameter logic [N_IN-1:0] ACTIVE_LOW_MASK = N_IN'(ACTIVE_LOW_MASK_DEFAULT),
    parameter int              DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int              REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int              REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic            clock_50,
    input  logic            reset,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] level,
    output logic [N_IN-1:0] press,
    output logic [N_IN-1:0] release_pulse
);

    // Channels share nothing but clock and reset, so simultaneous
    // actuations produce simultaneous pulses.
    for (genvar g = 0; g < N_IN; g++) begin : g_channel
        debounce_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[g]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .clock_50      (clock_50),
            .reset         (reset),
            .raw           (raw_in[g]),
            .level         (level[g]),
            .press         (press[g]),
            .release_pulse (release_pulse[g])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Bench for input_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. A change applied before edge k is expected in the outputs
// sampled after edge k+5 (2 sync stages + 3 counts + 1 update).
// Honours INPUT_CONDITIONER_REPEAT_EN to select the long-hold expectation.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    localparam logic [4:0] IDLE = 5'b01111;

    logic       clock_50 = 1'b0;
    logic       reset;
    logic [4:0] raw_in;
    logic [4:0] level;
    logic [4:0] press;
    logic [4:0] release_pulse;

    typedef struct packed {
        logic [4:0] lvl;
        logic [4:0] prs;
        logic [4:0] rel;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    input_conditioner #(
        .N_IN            (5),
        .ACTIVE_LOW_MASK (5'b01111),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clock_50      (clock_50),
        .reset         (reset),
        .raw_in        (raw_in),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse)
    );

    always #5 clock_50 = ~clock_50;

    // Advance one clock and land just after the active edge.
    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    // Expected outputs for n quiet cycles at a given level.
    function automatic void push_hold(input int n, input logic [4:0] lvl);
        for (int k = 0; k < n; k++) sb.push_back({lvl, 5'b00000, 5'b00000});
    endfunction

    // Expected outputs for the cycle in which level moves from one value to another.
    function automatic void push_edge(input logic [4:0] from, input logic [4:0] to);
        sb.push_back({to, to & ~from, from & ~to});
    endfunction

    task automatic test_reset();
        exp_t e;
        reset  = 1'b1;
        raw_in = IDLE;
        push_hold(23, 5'b00000);
        for (int i = 1; sb.size() > 0; i++) begin
            if (i == 4) reset = 1'b0;
            tick();
            e = sb.pop_front();
            checks++;
            if ({level, press, release_pulse} !== e) begin
                failures++;
                $display("[TB] FAIL test_reset cycle %0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         i, level, press, release_pulse, e.lvl, e.prs, e.rel);
            end
        end
    endtask

    task automatic test_press_key0();
        exp_t e;
        push_hold(5, 5'b00000);
        push_edge(5'b00000, 5'b00001);
        push_hold(4, 5'b00001);
        for (int i = 1; sb.size() > 0; i++) begin
            if (i == 1) raw_in[0] = 1'b0;
            tick();
            e = sb.pop_front();
            checks++;
            if ({level, press, release_pulse} !== e) begin
                failures++;
                $display("[TB] FAIL test_press_key0 cycle %0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         i, level, press, release_pulse, e.lvl, e.prs, e.rel);
            end
        end
    endtask

    // Enter bounces in 2-cycle runs, then settles; key0 is still held.
    task automatic test_bounce_enter();
        exp_t e;
        push_hold(13, 5'b00001);
        push_edge(5'b00001, 5'b10001);
        push_hold(3, 5'b10001);
        push_hold(5, 5'b10001);
        push_edge(5'b10001, 5'b00000);
        push_hold(3, 5'b00000);
        for (int i = 1; sb.size() > 0; i++) begin
            case (i)
                1, 5, 9: raw_in[4] = 1'b1;
                3, 7:    raw_in[4] = 1'b0;
                18:      raw_in    = IDLE;
                default: ;
            endcase
            tick();
            e = sb.pop_front();
            checks++;
            if ({level, press, release_pulse} !== e) begin
                failures++;
                $display("[TB] FAIL test_bounce_enter cycle %0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         i, level, press, release_pulse, e.lvl, e.prs, e.rel);
            end
        end
    endtask

    // A 3-cycle glitch is rejected; a 4-cycle press is just long enough.
    task automatic test_min_pulse();
        exp_t e;
        push_hold(17, 5'b00000);
        push_edge(5'b00000, 5'b01000);
        push_hold(3, 5'b01000);
        push_edge(5'b01000, 5'b00000);
        push_hold(3, 5'b00000);
        for (int i = 1; sb.size() > 0; i++) begin
            case (i)
                1, 13:   raw_in[3] = 1'b0;
                4, 17:   raw_in[3] = 1'b1;
                default: ;
            endcase
            tick();
            e = sb.pop_front();
            checks++;
            if ({level, press, release_pulse} !== e) begin
                failures++;
                $display("[TB] FAIL test_min_pulse cycle %0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         i, level, press, release_pulse, e.lvl, e.prs, e.rel);
            end
        end
    endtask

    // Reset while key2 is held, then reset during an in-flight release.
    task automatic test_reset_mid();
        exp_t e;
        push_hold(5, 5'b00000);
        push_edge(5'b00000, 5'b00100);
        push_hold(3, 5'b00100);
        push_hold(1, 5'b00000);
        push_hold(5, 5'b00000);
        push_edge(5'b00000, 5'b00100);
        push_hold(3, 5'b00100);
        push_hold(2, 5'b00100);
        push_hold(9, 5'b00000);
        for (int i = 1; sb.size() > 0; i++) begin
            case (i)
                1:       raw_in[2] = 1'b0;
                10, 22:  reset     = 1'b1;
                11, 23:  reset     = 1'b0;
                20:      raw_in[2] = 1'b1;
                default: ;
            endcase
            tick();
            e = sb.pop_front();
            checks++;
            if ({level, press, release_pulse} !== e) begin
                failures++;
                $display("[TB] FAIL test_reset_mid cycle %0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         i, level, press, release_pulse, e.lvl, e.prs, e.rel);
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        push_hold(5, 5'b00000);
        push_edge(5'b00000, 5'b10010);
        push_hold(8, 5'b10010);
        push_edge(5'b10010, 5'b00000);
        push_hold(3, 5'b00000);
        for (int i = 1; sb.size() > 0; i++) begin
            case (i)
                1:  begin raw_in[1] = 1'b0; raw_in[4] = 1'b1; end
                10: begin raw_in[1] = 1'b1; raw_in[4] = 1'b0; end
                default: ;
            endcase
            tick();
            e = sb.pop_front();
            checks++;
            if ({level, press, release_pulse} !== e) begin
                failures++;
                $display("[TB] FAIL test_simultaneous cycle %0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         i, level, press, release_pulse, e.lvl, e.prs, e.rel);
            end
        end
    endtask

    // Key0 accepted at cycle 6 and released at cycle 26 (20 cycles of hold).
    task automatic test_long_hold();
        exp_t e;
        logic rep;
        push_hold(5, 5'b00000);
        push_edge(5'b00000, 5'b00001);
        for (int t = 7; t <= 25; t++) begin
`ifdef INPUT_CONDITIONER_REPEAT_EN
            rep = (t == 16) || (t == 19) || (t == 22) || (t == 25);
`else
            rep = 1'b0;
`endif
            sb.push_back({5'b00001, {4'b0000, rep}, 5'b00000});
        end
        push_edge(5'b00001, 5'b00000);
        push_hold(6, 5'b00000);
        for (int i = 1; sb.size() > 0; i++) begin
            case (i)
                1:       raw_in[0] = 1'b0;
                21:      raw_in[0] = 1'b1;
                default: ;
            endcase
            tick();
            e = sb.pop_front();
            checks++;
            if ({level, press, release_pulse} !== e) begin
                failures++;
                $display("[TB] FAIL test_long_hold cycle %0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         i, level, press, release_pulse, e.lvl, e.prs, e.rel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_key0();
        test_bounce_enter();
        test_min_pulse();
        test_reset_mid();
        test_simultaneous();
        test_long_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
